pattern_load_sequencer: RTL and testbench
=========================================

# pattern_load_sequencer

Upstream feeder for the cycle-left rotator. It buffers MSB-bit patterns in a small FIFO and, while enabled, issues them to the rotator as one-cycle load pulses with data. Consecutive loads are separated by a fixed number of rotation cycles, so each pattern rotates for a known time before the next one replaces it. `o_load` and `o_din` connect directly to the rotator's `i_load` and `din`.

## Interface
- MSB, 4: pattern width; must match the rotator's MSB.
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- HOLD, 5: idle (rotation) cycles between consecutive load pulses; ≥1.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous reset, active-low (0 = reset).
- i_wr_en  in  1  pushes `i_wr_data` when `o_full`=0.
- i_wr_data  in  MSB  pattern to enqueue.
- i_start  in  1  level enable for sequencing.
- o_full  out  1  FIFO holds DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_level  out  $clog2(DEPTH)+1  current occupancy.
- o_load  out  1  one-cycle load strobe to the rotator.
- o_din  out  MSB  pattern presented with the strobe.
- o_busy  out  1  FSM is not in IDLE.

## Operation
- FIFO:
  - Circular buffer with separate read and write pointers plus a level counter.
  - A write is accepted iff `i_wr_en`=1 and `o_full`=0, judged on the current-cycle flag.
  - A write while full is dropped silently, even when a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: on an edge with `i_start`=1 and `o_empty`=0, go to LOAD. On that edge, set the registered `o_load`=1, set `o_din`=FIFO head, and pop.
  - LOAD: on the next edge, clear `o_load` and go to RUN with hold counter = HOLD-1.
  - RUN: decrement the counter each edge. When the counter is 0:
    - If `i_start`=1 and `o_empty`=0, go to LOAD (pop, `o_load`=1, new `o_din`).
    - Otherwise go to IDLE.
- `o_din` holds the last loaded pattern until the next load. The rotator samples it only while `o_load`=1.
- Deasserting `i_start` in LOAD or RUN does not abort the current hold. The FSM finishes RUN and then returns to IDLE.
- A FIFO that becomes empty during RUN ends the sequence in IDLE. A later write with `i_start`=1 restarts it.
- `o_busy`=1 in LOAD and RUN.
- Reset (`i_rst`=0 at an edge) returns the FSM to IDLE and clears the pointers, level and counter. Buffered patterns are discarded. This applies mid-sequence as well.

## Timing
- Reset values: `o_load`=0, `o_din`=0, `o_busy`=0, `o_full`=0, `o_empty`=1, `o_level`=0.
- All outputs are registered; there is no combinational path from input to output.
- Write latency: data written at edge t counts in `o_level` and `o_empty` after t. The earliest resulting load edge is t+1.
- `o_load` is high for exactly one clock cycle per pattern.
- With the FIFO non-empty and `i_start` held at 1, load pulses recur with period HOLD+1 cycles, i.e. HOLD low cycles between pulses.
- A load that pops the last entry sets `o_empty`=1 on the same edge.
- Patterns leave the FIFO in strict write order. No pattern is ever emitted twice or skipped.

## Test plan
- Reset: hold `i_rst`=0 for 2 edges with `i_wr_en`=1 and `i_start`=1. Required: all outputs at reset values, no write accepted. Release reset: normal operation from the next edge.
- Single pattern: write 1011 with `i_start`=1. Required: one `o_load` pulse with `o_din`=1011, then 5 low cycles, then IDLE with `o_busy`=0. The rotator `dout` sequence is 1011, 0111, 1110, 1101, 1011.
- Back-to-back patterns: write 1011 then 0101, then set `i_start`=1. Required: load pulses exactly 6 cycles apart carrying 1011 then 0101. `o_empty`=1 from the second pulse onward.
- Full and overflow: with `i_start`=0, write 4 values 0001, 0010, 0100, 1000, then write 1111. Required: `o_full`=1, `o_level`=4, 1111 dropped. Start: loads occur in order 0001, 0010, 0100, 1000.
- Simultaneous write while full: with the FIFO full and a pop occurring on the same edge as a write of 1111, 1111 is dropped and `o_level` becomes 3. With the FIFO at 3 entries, a write on the pop edge is accepted and `o_level` stays 3.
- Stop and reset mid-sequence: drop `i_start` 2 cycles after a load. Required: no further pulse, IDLE after the hold completes. Assert reset during RUN with 2 entries buffered: IDLE next edge, `o_level`=0, no later loads.

Source files
------------

// File: rtl/pattern_load_sequencer.sv
// Pattern FIFO feeding the cycle-left rotator. While enabled, it issues one-cycle
// load strobes spaced HOLD rotation cycles apart.
module pattern_load_sequencer #(
    parameter int unsigned MSB   = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [MSB-1:0]           i_wr_data,
    input  logic                     i_start,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_load,
    output logic [MSB-1:0]           o_din,
    output logic                     o_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_q, load_d;
    logic [MSB-1:0]     din_q, din_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic [MSB-1:0]     mem_q [DEPTH];
    logic [MSB-1:0]     mem_d [DEPTH];
    logic               pop;
    logic               wr_acc;

    // Sequencer: a pop and the load strobe always happen on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        din_d   = din_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start && !empty_q) begin
                    state_d = S_LOAD;
                    load_d  = 1'b1;
                    din_d   = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                cnt_d   = CNT_W'(HOLD - 1);
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    if (i_start && !empty_q) begin
                        state_d = S_LOAD;
                        load_d  = 1'b1;
                        din_d   = mem_q[rd_ptr_q];
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; a write is judged on the registered full flag only.
    always_comb begin
        wr_acc   = i_wr_en && !full_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = i_wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_acc, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            mem_q    <= mem_d;
        end
    end

    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_level = level_q;
    assign o_load  = load_q;
    assign o_din   = din_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_pattern_load_sequencer.sv
// Bench for pattern_load_sequencer: directed scenarios plus random traffic,
// checked each cycle against a time-based queue model.
module tb_pattern_load_sequencer;

    localparam int unsigned MSB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 5;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic               i_clk;
    logic               i_rst;
    logic               i_wr_en;
    logic [MSB-1:0]     i_wr_data;
    logic               i_start;
    logic               o_full;
    logic               o_empty;
    logic [LVL_W-1:0]   o_level;
    logic               o_load;
    logic [MSB-1:0]     o_din;
    logic               o_busy;

    pattern_load_sequencer #(
        .MSB   (MSB),
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_start   (i_start),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level),
        .o_load    (o_load),
        .o_din     (o_din),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued patterns, time of the last load, and whether a sequence is active.
    logic [MSB-1:0] m_q[$];
    int             m_last   = -100;
    bit             m_active = 1'b0;
    logic [MSB-1:0] m_din    = '0;
    int             cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick(input logic rst_n, input logic wr, input logic [MSB-1:0] d, input logic st);
        bit can_load;
        bit accept;
        @(negedge i_clk);
        i_rst     = rst_n;
        i_wr_en   = wr;
        i_wr_data = d;
        i_start   = st;
        @(posedge i_clk);
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_last   = -100;
            m_din    = '0;
        end else begin
            can_load = !m_active || (cyc - m_last == int'(HOLD) + 1);
            accept   = wr && (m_q.size() < int'(DEPTH));
            if (can_load && st && m_q.size() > 0) begin
                m_din    = m_q.pop_front();
                m_last   = cyc;
                m_active = 1'b1;
            end else if (m_active && (cyc - m_last == int'(HOLD) + 1)) begin
                m_active = 1'b0;
            end
            if (accept) m_q.push_back(d);
        end
        #1;
        check("load",  32'(o_load),  32'(m_last == cyc));
        check("din",   32'(o_din),   32'(m_din));
        check("busy",  32'(o_busy),  32'(m_active));
        check("level", 32'(o_level), 32'(m_q.size()));
        check("full",  32'(o_full),  32'(m_q.size() == int'(DEPTH)));
        check("empty", 32'(o_empty), 32'(m_q.size() == 0));
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, st);
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int second_pulse;
        logic st_r;
        i_rst = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_start = 1'b0;

        // Reset held two edges while writing and enabled.
        tick(1'b0, 1'b1, 4'b1011, 1'b1);
        tick(1'b0, 1'b1, 4'b1011, 1'b1);
        check("rst_level", 32'(o_level), 32'd0);

        // Single pattern.
        tick(1'b1, 1'b1, 4'b1011, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, '0, 1'b1);
            if (o_load) begin
                pulses++;
                check("single_din", 32'(o_din), 32'(4'b1011));
            end
        end
        check("single_pulses", 32'(pulses), 32'd1);
        check("single_idle", 32'(o_busy), 32'd0);

        // Back-to-back patterns, six cycles apart.
        tick(1'b1, 1'b1, 4'b1011, 1'b0);
        tick(1'b1, 1'b1, 4'b0101, 1'b0);
        first_pulse = -1; second_pulse = -1;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, '0, 1'b1);
            if (o_load) begin
                if (first_pulse < 0) first_pulse = cyc;
                else second_pulse = cyc;
            end
        end
        check("b2b_spacing", 32'(second_pulse - first_pulse), 32'(HOLD + 1));

        // Fill, overflow, then pop-while-full drop and accepted write on a pop edge.
        tick(1'b1, 1'b1, 4'b0001, 1'b0);
        tick(1'b1, 1'b1, 4'b0010, 1'b0);
        tick(1'b1, 1'b1, 4'b0100, 1'b0);
        tick(1'b1, 1'b1, 4'b1000, 1'b0);
        tick(1'b1, 1'b1, 4'b1111, 1'b0);
        check("ovf_level", 32'(o_level), 32'd4);
        tick(1'b1, 1'b1, 4'b1111, 1'b1);
        check("popfull_level", 32'(o_level), 32'd3);
        idle(5, 1'b1);
        tick(1'b1, 1'b1, 4'b1010, 1'b1);
        check("popwr_level", 32'(o_level), 32'd3);
        idle(30, 1'b1);

        // Stop two cycles after a load.
        tick(1'b1, 1'b1, 4'b0110, 1'b0);
        tick(1'b1, 1'b1, 4'b1001, 1'b1);
        idle(2, 1'b1);
        idle(12, 1'b0);
        check("stop_level", 32'(o_level), 32'd1);

        // Reset during RUN with two entries buffered.
        tick(1'b1, 1'b1, 4'b1100, 1'b1);
        idle(2, 1'b1);
        tick(1'b1, 1'b1, 4'b0011, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        idle(10, 1'b1);

        // Random traffic.
        st_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) st_r = ~st_r;
            tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 3),
                 MSB'($urandom), st_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
